// File: rtl/pet_prg_pkg.sv
// Shared types and constants for the PET .PRG download loader.
package pet_prg_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_HDR_LO  = 3'd1;
   localparam state_t ST_HDR_HI  = 3'd2;
   localparam state_t ST_DATA    = 3'd3;
   localparam state_t ST_PATCH   = 3'd4;
   localparam state_t ST_AUTORUN = 3'd5;
   localparam state_t ST_DONE    = 3'd6;

   localparam logic [15:0] KBUF_ADDR = 16'h026F;
   localparam logic [15:0] KBUF_CNT  = 16'h009E;

   localparam int unsigned AUTORUN_LEN = 4;
   localparam logic [7:0] AUTORUN_TEXT [AUTORUN_LEN] = '{8'h52, 8'h55, 8'h4E, 8'h0D};

endpackage

// File: rtl/pet_prg_loader.sv
// PET .PRG loader: streams a downloaded program into main RAM through the DMA
// port, then patches VARTAB/ARYTAB/STREND to the end address.
// Optional build macro PET_PRG_AUTORUN_EN adds an AUTORUN state that types
// "RUN<CR>" into the keyboard buffer after the pointer patch.
module pet_prg_loader
   import pet_prg_pkg::*;
#(
   parameter logic [15:0]  RAM_TOP   = 16'h7FFF,
   parameter logic [7:0]   PTR_BASE  = 8'h2A,
   parameter int unsigned  PTR_COUNT = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dl_active,
   input  logic        dl_wr,
   input  logic [7:0]  dl_data,
   output logic        dl_wait,
   output logic [14:0] dma_addr,
   output logic [7:0]  dma_din,
   output logic        dma_we,
   output logic        busy,
   output logic        load_done,
   output logic        load_err
);

   localparam int unsigned IDX_W     = 4;
   localparam int unsigned PATCH_LEN = 2 * PTR_COUNT;

   state_t             state, state_n;
   logic               act_q;
   logic [15:0]        cur, cur_n;
   logic [15:0]        end_addr, end_n;
   logic               ovf, ovf_n;
   logic [IDX_W-1:0]   idx, idx_n;

   logic               rise, fall;
   logic               wait_n, we_n, busy_n, done_n, err_n;
   logic [14:0]        addr_n;
   logic [7:0]         din_n;

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         act_q     <= 1'b0;
         cur       <= 16'h0000;
         end_addr  <= 16'h0000;
         ovf       <= 1'b0;
         idx       <= '0;
         dl_wait   <= 1'b0;
         dma_addr  <= 15'h0000;
         dma_din   <= 8'h00;
         dma_we    <= 1'b0;
         busy      <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         state     <= state_n;
         act_q     <= dl_active;
         cur       <= cur_n;
         end_addr  <= end_n;
         ovf       <= ovf_n;
         idx       <= idx_n;
         dl_wait   <= wait_n;
         dma_addr  <= addr_n;
         dma_din   <= din_n;
         dma_we    <= we_n;
         busy      <= busy_n;
         load_done <= done_n;
         load_err  <= err_n;
      end
   end

   // Next-state, write sequencing and output decode.
   always_comb begin
      state_n = state;
      cur_n   = cur;
      end_n   = end_addr;
      ovf_n   = ovf;
      idx_n   = idx;
      err_n   = load_err;
      we_n    = 1'b0;
      addr_n  = dma_addr;
      din_n   = dma_din;
      rise    = dl_active & ~act_q;
      fall    = ~dl_active & act_q;

      case (state)
         ST_IDLE: begin
            if (rise) begin
               state_n = ST_HDR_LO;
               err_n   = 1'b0;
               ovf_n   = 1'b0;
               idx_n   = '0;
            end
         end

         ST_HDR_LO: begin
            if (dl_wr) begin
               cur_n   = {cur[15:8], dl_data};
               state_n = ST_HDR_HI;
            end
            // Truncated header: abandon without patching.
            if (fall) begin
               err_n   = 1'b1;
               state_n = ST_DONE;
            end
         end

         ST_HDR_HI: begin
            if (dl_wr) begin
               cur_n = {dl_data, cur[7:0]};
               if (fall) begin
                  end_n   = cur_n;
                  idx_n   = '0;
                  state_n = ST_PATCH;
               end else begin
                  state_n = ST_DATA;
               end
            end else if (fall) begin
               err_n   = 1'b1;
               state_n = ST_DONE;
            end
         end

         ST_DATA: begin
            if (dl_wr) begin
               // Once past RAM_TOP, cur only returns in range through a wrap.
               if (cur <= RAM_TOP && !ovf) begin
                  we_n   = 1'b1;
                  addr_n = cur[14:0];
                  din_n  = dl_data;
               end else begin
                  ovf_n = 1'b1;
                  err_n = 1'b1;
               end
               cur_n = cur + 16'd1;
            end
            if (fall) begin
               if (ovf_n) begin
                  state_n = ST_DONE;
               end else begin
                  end_n   = cur_n;
                  idx_n   = '0;
                  state_n = ST_PATCH;
               end
            end
         end

         ST_PATCH: begin
            we_n   = 1'b1;
            addr_n = 15'(16'(PTR_BASE) + 16'(idx));
            din_n  = idx[0] ? end_addr[15:8] : end_addr[7:0];
            idx_n  = idx + IDX_W'(1);
            if (idx == IDX_W'(PATCH_LEN - 1)) begin
               idx_n = '0;
`ifdef PET_PRG_AUTORUN_EN
               state_n = ST_AUTORUN;
`else
               state_n = ST_DONE;
`endif
            end
         end

`ifdef PET_PRG_AUTORUN_EN
         ST_AUTORUN: begin
            we_n  = 1'b1;
            idx_n = idx + IDX_W'(1);
            if (idx < IDX_W'(AUTORUN_LEN)) begin
               addr_n = 15'(KBUF_ADDR + 16'(idx));
               din_n  = AUTORUN_TEXT[idx[1:0]];
            end else begin
               addr_n  = 15'(KBUF_CNT);
               din_n   = 8'(AUTORUN_LEN);
               idx_n   = '0;
               state_n = ST_DONE;
            end
         end
`endif

         ST_DONE: begin
            state_n = ST_IDLE;
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase

      wait_n = (state_n == ST_PATCH) || (state_n == ST_AUTORUN);
      done_n = (state == ST_DONE) && !load_err;
      // Hold busy through the load_done pulse so the CPU leaves reset after it.
      busy_n = (state_n != ST_IDLE) || done_n;
   end

endmodule

// File: tb/tb_pet_prg_loader.sv
// Randomized self-checking bench for pet_prg_loader with a write-list model.
module tb_pet_prg_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        dl_active;
   logic        dl_wr;
   logic [7:0]  dl_data;
   logic        dl_wait;
   logic [14:0] dma_addr;
   logic [7:0]  dma_din;
   logic        dma_we;
   logic        busy;
   logic        load_done;
   logic        load_err;

   pet_prg_loader dut (
      .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
      .dl_data(dl_data), .dl_wait(dl_wait), .dma_addr(dma_addr),
      .dma_din(dma_din), .dma_we(dma_we), .busy(busy),
      .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   // kind 0: data write at exact cycle; 1: first patch write; 2: follows previous write
   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      int          cyc;
      int          kind;
   } wr_t;

   wr_t         exp_q[$];
   logic [15:0] log_a[$];
   logic [7:0]  log_d[$];
   int          cyc = 0;
   int          nwr = 0;
   int          done_cnt = 0;
   int          last_we_cyc = -10;
   int          total = 0;
   int          bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Compare every DMA write against the expected write list.
   always @(negedge clk) begin
      if (reset_n) begin
         if (dma_we) begin
            wr_t e;
            nwr++;
            log_a.push_back({1'b0, dma_addr});
            log_d.push_back(dma_din);
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {17'h0, dma_addr}, 32'hFFFFFFFF);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", {17'h0, dma_addr}, {17'h0, e.addr[14:0]});
               chk("wr_data", {24'h0, dma_din}, {24'h0, e.data});
               if (e.kind == 0) chk("wr_latency", cyc, e.cyc);
               if (e.kind == 2) chk("wr_contiguous", cyc, last_we_cyc + 1);
            end
            last_we_cyc = cyc;
         end
         if (load_done) done_cnt++;
      end
   end

   task automatic send_byte(input logic [7:0] b, input int ua, input bit fall);
      int guard = 0;
      while (dl_wait && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      dl_wr   = 1'b1;
      dl_data = b;
      if (fall) dl_active = 1'b0;
      if (ua >= 0 && ua <= 32'h7FFF) begin
         wr_t w;
         w.addr = ua[15:0];
         w.data = b;
         w.cyc  = cyc + 1;
         w.kind = 0;
         exp_q.push_back(w);
      end
      @(negedge clk);
      dl_wr = 1'b0;
   endtask

   task automatic push_wr(input logic [15:0] a, input logic [7:0] d, input int kind);
      wr_t w;
      w.addr = a;
      w.data = d;
      w.cyc  = 0;
      w.kind = kind;
      exp_q.push_back(w);
   endtask

   // One full download; rst_after >= 0 pulses reset after that many patch writes.
   task automatic do_load(input logic [15:0] la, input logic [7:0] bytes[$],
                          input int gap_pct, input bit fall_last, input int rst_after);
      int          n = bytes.size();
      bit          err = 1'b0;
      int          nin = 0;
      int          start_nwr;
      logic [15:0] e;
      int          guard;
      done_cnt  = 0;
      start_nwr = nwr;
      @(negedge clk);
      dl_active = 1'b1;
      @(negedge clk);
      send_byte(la[7:0], -1, 1'b0);
      send_byte(la[15:8], -1, 1'b0);
      for (int i = 0; i < n; i++) begin
         int ua = int'(la) + i;
         if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) @(negedge clk);
         if (ua > 32'h7FFF) err = 1'b1; else nin++;
         send_byte(bytes[i], ua, fall_last && (i == n - 1));
      end
      dl_active = 1'b0;
      e = la + 16'(n);
      if (!err) begin
         for (int p = 0; p < 3; p++) begin
            push_wr(16'h002A + 16'(2 * p), e[7:0], (p == 0) ? 1 : 2);
            push_wr(16'h002B + 16'(2 * p), e[15:8], 2);
         end
`ifdef PET_PRG_AUTORUN_EN
         push_wr(16'h026F, 8'h52, 2);
         push_wr(16'h0270, 8'h55, 2);
         push_wr(16'h0271, 8'h4E, 2);
         push_wr(16'h0272, 8'h0D, 2);
         push_wr(16'h009E, 8'h04, 2);
`endif
      end
      if (rst_after >= 0) begin
         guard = 0;
         while (nwr < start_nwr + nin + rst_after && guard < 200) begin
            @(posedge clk);
            #2;
            guard++;
         end
         chk("patch_reached", guard < 200, 1);
         reset_n = 1'b0;
         #1;
         chk("rst_dma_we", dma_we, 0);
         chk("rst_busy", busy, 0);
         chk("rst_wait", dl_wait, 0);
         chk("rst_err", load_err, 0);
         exp_q.delete();
         @(negedge clk);
         reset_n = 1'b1;
         repeat (3) @(negedge clk);
         chk("rst_no_writes", dma_we, 0);
         return;
      end
      guard = 0;
      while (busy && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("busy_timeout", busy, 0);
      repeat (2) @(negedge clk);
      chk("missing_writes", exp_q.size(), 0);
      chk("done_count", done_cnt, err ? 0 : 1);
      chk("load_err", load_err, err);
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] q[$];
      int         base;
      reset_n   = 1'b0;
      dl_active = 1'b0;
      dl_wr     = 1'b0;
      dl_data   = 8'h00;
      #23;
      chk("reset_we", dma_we, 0);
      chk("reset_addr", {17'h0, dma_addr}, 0);
      chk("reset_din", {24'h0, dma_din}, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", load_done, 0);
      chk("reset_err", load_err, 0);
      chk("reset_wait", dl_wait, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Basic load at $0401.
      base = log_a.size();
      q = '{8'hAA, 8'hBB, 8'hCC};
      do_load(16'h0401, q, 0, 1'b0, -1);
      chk("t1_first_addr", {16'h0, log_a[base]}, 32'h0401);
      chk("t1_first_data", {24'h0, log_d[base]}, 32'hAA);
      chk("t1_last_addr", {16'h0, log_a[base + 2]}, 32'h0403);
      chk("t1_vartab_lo", {16'h0, log_a[base + 3], log_d[base + 3]}, 32'h002A04);
      chk("t1_strend_hi", {16'h0, log_a[base + 8], log_d[base + 8]}, 32'h002F04);
`ifdef PET_PRG_AUTORUN_EN
      chk("t1_kbuf_r", {16'h0, log_a[base + 9], log_d[base + 9]}, 32'h026F52);
      chk("t1_kbuf_cnt", {16'h0, log_a[base + 13], log_d[base + 13]}, 32'h009E04);
`endif

      // 256 back-to-back bytes from $1000.
      base = log_a.size();
      q.delete();
      for (int i = 0; i < 256; i++) q.push_back(8'(i * 7 + 3));
      do_load(16'h1000, q, 0, 1'b0, -1);
      chk("t2_vartab_lo", {16'h0, log_a[base + 256], log_d[base + 256]}, 32'h002A00);
      chk("t2_vartab_hi", {16'h0, log_a[base + 257], log_d[base + 257]}, 32'h002B11);

      // Overflow at the top of RAM.
      base = nwr;
      q = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_load(16'h7FFE, q, 0, 1'b0, -1);
      chk("t3_write_count", nwr - base, 2);
      chk("t3_top_addr", {16'h0, log_a[log_a.size() - 1]}, 32'h7FFF);

      // Truncated header.
      base = nwr;
      done_cnt = 0;
      @(negedge clk);
      dl_active = 1'b1;
      @(negedge clk);
      send_byte(8'h01, -1, 1'b0);
      dl_active = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("t4_busy_low", busy, 0);
      chk("t4_err", load_err, 1);
      chk("t4_no_writes", nwr - base, 0);
      chk("t4_no_done", done_cnt, 0);
      repeat (2) @(negedge clk);

      // Reset during patch, then a clean reload.
      q = '{8'h5A, 8'hA5};
      do_load(16'h2000, q, 0, 1'b0, 2);
      q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      do_load(16'h0C00, q, 20, 1'b1, -1);

      // Randomized loads, including zero length, top-of-RAM and wrap cases.
      for (int t = 0; t < 14; t++) begin
         logic [15:0] la;
         int          n;
         case ($urandom_range(3, 0))
            0: la = 16'($urandom_range(32'h7F00, 0));
            1: la = 16'h7FE8 + 16'($urandom_range(31, 0));
            2: la = 16'hFFF0 + 16'($urandom_range(15, 0));
            default: la = 16'h0401 + 16'($urandom_range(255, 0));
         endcase
         n = $urandom_range(24, 0);
         q.delete();
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         do_load(la, q, ($urandom_range(1, 0) == 1) ? 30 : 0,
                 (n > 0) && ($urandom_range(1, 0) == 1), -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pet_prg_loader.md
Name: pet_prg_loader

Overview:
- Upstream neighbour of the PET hardware top; drives its RAM DMA port (dma_addr/dma_din/dma_we).
- Consumes a byte stream from the OSD file-download channel in .PRG format: a 2-byte little-endian load address, then payload.
- Writes the payload into the 32KB main RAM, then patches the BASIC end-of-program pointers so that RUN/LIST work without a manual relink.

Parameters:
- RAM_TOP, 16'h7FFF, highest writable RAM address; payload bytes above it are dropped.
- PTR_BASE, 8'h2A, zero-page address of VARTAB (BASIC 2/4); ARYTAB and STREND follow at +2 and +4.
- PTR_COUNT, 3, number of 16-bit pointers patched with the end address.

Ports:
- clk  in  1  system clock (same as the hardware top).
- reset_n  in  1  asynchronous, active-low reset.
- dl_active  in  1  high for the whole download; the falling edge marks end of file.
- dl_wr  in  1  one-cycle strobe; dl_data is valid in that cycle.
- dl_data  in  8  stream byte.
- dl_wait  out  1  high = loader cannot accept dl_wr; the source holds its strobe off.
- dma_addr  out  15  RAM write address.
- dma_din  out  8  RAM write data.
- dma_we  out  1  RAM write enable, single-cycle pulse.
- busy  out  1  high from dl_active rise until the FSM returns to IDLE; used to hold the CPU in reset.
- load_done  out  1  one-cycle pulse on successful completion.
- load_err  out  1  sticky error flag; cleared on the next dl_active rise.

Behaviour:
- Reset: all outputs 0. FSM in IDLE. Internal addr/end registers are 0.
- FSM states: IDLE -> HDR_LO -> HDR_HI -> DATA -> PATCH -> DONE -> IDLE.
- IDLE: a rising edge of dl_active clears load_err, sets busy, and goes to HDR_LO.
- HDR_LO / HDR_HI:
  - dl_wr latches the low / high byte of the 16-bit load address.
  - The cur address register is set to the load address.
  - No RAM write happens in these states.
- DATA: each accepted dl_wr at cycle N produces, at N+1:
  - dma_we=1, dma_addr=cur[14:0], dma_din=the byte;
  - cur incremented (16-bit).
  - One byte per cycle is sustained. dl_wait=0.
- Overflow: a byte with cur > RAM_TOP (including wrap past FFFF) is not written. overflow flag and load_err are set, and cur still increments.
- End of file, dl_active falling:
  - In HDR_LO or HDR_HI: load_err=1, go to DONE. No patch, no load_done.
  - In DATA with the overflow flag set: go to DONE with load_err=1 and no patch.
  - In DATA otherwise: end = cur (address after the last byte), go to PATCH.
  - A final dl_wr in the same cycle as the fall is accepted first.
- PATCH: dl_wait=1. Issues 2*PTR_COUNT consecutive single-cycle writes:
  - addresses PTR_BASE+0..5;
  - data end[7:0], end[15:8], repeated for each pointer;
  - no idle cycles between writes.
- DONE: one cycle. load_done=1 only if load_err=0. busy drops in the following cycle (IDLE).
- Zero-length payload (header only): end = load address; patch proceeds normally.
- dl_active rising while not IDLE: ignored. A new load starts only from IDLE with dl_active low->high.
- dl_wr outside HDR_LO/HDR_HI/DATA is ignored.
- reset_n low mid-operation: immediate return to IDLE. dma_we deasserts asynchronously. A partial load is abandoned with no patch.
- Width rule: all address arithmetic is 16-bit. dma_addr is the low 15 bits, used only when the range check passes.

Optional Feature:
- Macro PET_PRG_AUTORUN_EN.
- Defined: after PATCH, an AUTORUN state writes 'R','U','N',8'h0D to keyboard buffer $026F..$0272, then 8'h04 to $009E, over 5 consecutive cycles, before DONE.
- Not defined: PATCH goes directly to DONE and the AUTORUN state does not exist.

Decomposition:
- Shared package pet_prg_pkg:
  - state enum typedef;
  - constants KBUF_ADDR=16'h026F, KBUF_CNT=16'h009E, AUTORUN_TEXT array.
- Single module, no sub-module. The patch/autorun write sequencer is a counter indexing a small constant table, kept inline.

Test Plan:
- Load header 01 04 + 3 bytes AA BB CC -> writes at 0401/0402/0403. After the dl_active fall: 2A=04 2B=04 2C=04 2D=04 2E=04 2F=04, then load_done pulse, load_err=0.
- Back-to-back dl_wr every cycle for 256 bytes from $1000 -> 256 contiguous dma_we pulses, each one cycle after its strobe. VARTAB=$1100.
- Header FE 7F + 4 bytes -> only $7FFE/$7FFF written, load_err=1, no pointer writes, no load_done.
- dl_active falls after 1 byte -> load_err=1, zero dma_we pulses, busy low within 2 cycles.
- reset_n pulsed low during PATCH (after 2 of 6 writes) -> dma_we=0 immediately, busy=0, FSM IDLE. A new download then completes normally.
- With PET_PRG_AUTORUN_EN: header 01 04 + 1 byte -> patch writes followed by $026F..$0272 = 52 55 4E 0D and $009E=04, then load_done.
